// File: rtl/block_window_manager.sv
// rtl/block_window_manager.sv - per-frame window of upcoming song blocks feeding the pixel block selector
// Build option: define MISS_COUNT_EN to count blocks that expire without being hit (miss_count_out).
module block_window_manager #(
  parameter int NUM_SLOTS   = 12,
  parameter int NUM_BLOCKS  = 256,
  parameter int LOOKAHEAD   = 4096,
  parameter int EXPIRE      = 512,
  parameter int MEM_LATENCY = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [17:0]                  curr_time_in,
  input  logic                         frame_start_in,
  input  logic                         hit_valid_in,
  input  logic [3:0]                   hit_index_in,
  output logic                         hit_ready_out,
  output logic [7:0]                   mem_addr_out,
  input  logic [45:0]                  mem_data_in,
  output logic [NUM_SLOTS-1:0][11:0]   block_x_out,
  output logic [NUM_SLOTS-1:0][11:0]   block_y_out,
  output logic [NUM_SLOTS-1:0][13:0]   block_z_out,
  output logic [NUM_SLOTS-1:0]         block_color_out,
  output logic [NUM_SLOTS-1:0][2:0]    block_direction_out,
  output logic [NUM_SLOTS-1:0]         block_visible_out,
  output logic                         busy_out,
  output logic                         done_out,
  output logic [7:0]                   miss_count_out
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int NA_W  = $clog2(NUM_BLOCKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVICT,
    S_FETCH,
    S_WAIT,
    S_LOAD
  } state_t;

  state_t               state;
  logic [17:0]          frame_time_q;
  logic [17:0]          slot_time [NUM_SLOTS];
  logic [11:0]          slot_x    [NUM_SLOTS];
  logic [11:0]          slot_y    [NUM_SLOTS];
  logic [2:0]           slot_dir  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] slot_color;
  logic [NUM_SLOTS-1:0] slot_hit;
  logic [CNT_W-1:0]     count;
  logic [NA_W-1:0]      next_addr;
  logic [3:0]           wait_cnt;

  // Record fields as laid out in song memory
  logic [17:0] rec_time;
  logic [11:0] rec_x;
  logic [11:0] rec_y;
  logic        rec_color;
  logic [2:0]  rec_dir;

  assign rec_time  = mem_data_in[45:28];
  assign rec_x     = mem_data_in[27:16];
  assign rec_y     = mem_data_in[15:4];
  assign rec_color = mem_data_in[3];
  assign rec_dir   = mem_data_in[2:0];

  logic                 hit_accept;
  logic                 fetch_stop;
  logic                 load_ok;
  logic [NUM_SLOTS-1:0] slot_live;
  logic [NUM_SLOTS-1:0] slot_expired;
  logic                 evict_found;
  logic [CNT_W-1:0]     evict_idx;
  logic [13:0]          slot_z [NUM_SLOTS];

  assign hit_accept = hit_valid_in && hit_ready_out && (32'(hit_index_in) < 32'(count));
  assign fetch_stop = (count == CNT_W'(NUM_SLOTS)) || (next_addr == NA_W'(NUM_BLOCKS));
  // 19-bit compare so frame_time + LOOKAHEAD never wraps
  assign load_ok    = ({1'b0, rec_time} <= ({1'b0, frame_time_q} + 19'(LOOKAHEAD)));

  // Signed distance from the frame time to a block, clamped to the 14-bit z range
  function automatic logic [13:0] sat_z(input logic [17:0] t, input logic [17:0] f);
    logic signed [18:0] d;
    d = $signed({1'b0, t}) - $signed({1'b0, f});
    if (d > 19'sd8191)
      return 14'h1FFF;
    else if (d < -19'sd8192)
      return 14'h2000;
    else
      return d[13:0];
  endfunction

  // Per-slot occupancy, expiry and z distance
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_live[i]    = (i < int'(count));
      slot_expired[i] = ({1'b0, frame_time_q} > ({1'b0, slot_time[i]} + 19'(EXPIRE)));
      slot_z[i]       = sat_z(slot_time[i], frame_time_q);
    end
  end

  // Lowest occupied slot that is hit or expired; scanning downward leaves the lowest match
  always_comb begin
    evict_found = 1'b0;
    evict_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_live[i] && (slot_hit[i] || slot_expired[i])) begin
        evict_found = 1'b1;
        evict_idx   = CNT_W'(i);
      end
    end
  end

  // Update sequencer: hit capture, one-per-cycle eviction with compaction, and refill from song memory
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= S_IDLE;
      frame_time_q  <= '0;
      count         <= '0;
      next_addr     <= '0;
      wait_cnt      <= '0;
      slot_hit      <= '0;
      slot_color    <= '0;
      hit_ready_out <= 1'b1;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
      mem_addr_out  <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_time[i] <= '0;
        slot_x[i]    <= '0;
        slot_y[i]    <= '0;
        slot_dir[i]  <= '0;
      end
    end else begin
      done_out <= 1'b0;
      case (state)
        S_IDLE: begin
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (hit_accept && (4'(i) == hit_index_in))
              slot_hit[i] <= 1'b1;
          end
          if (frame_start_in) begin
            frame_time_q  <= curr_time_in;
            state         <= S_EVICT;
            busy_out      <= 1'b1;
            hit_ready_out <= 1'b0;
          end
        end

        S_EVICT: begin
          if (evict_found) begin
            for (int j = 0; j < NUM_SLOTS - 1; j++) begin
              if (CNT_W'(j) >= evict_idx) begin
                slot_time[j]  <= slot_time[j+1];
                slot_x[j]     <= slot_x[j+1];
                slot_y[j]     <= slot_y[j+1];
                slot_dir[j]   <= slot_dir[j+1];
                slot_color[j] <= slot_color[j+1];
                slot_hit[j]   <= slot_hit[j+1];
              end
            end
            slot_hit[NUM_SLOTS-1] <= 1'b0;
            count <= count - CNT_W'(1);
          end else begin
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (fetch_stop) begin
            state         <= S_IDLE;
            busy_out      <= 1'b0;
            done_out      <= 1'b1;
            hit_ready_out <= 1'b1;
          end else begin
            mem_addr_out <= 8'(next_addr);
            wait_cnt     <= '0;
            state        <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (int'(wait_cnt) + 2 >= MEM_LATENCY)
            state <= S_LOAD;
          else
            wait_cnt <= wait_cnt + 4'd1;
        end

        S_LOAD: begin
          if (load_ok) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
              if (CNT_W'(i) == count) begin
                slot_time[i]  <= rec_time;
                slot_x[i]     <= rec_x;
                slot_y[i]     <= rec_y;
                slot_dir[i]   <= rec_dir;
                slot_color[i] <= rec_color;
                slot_hit[i]   <= 1'b0;
              end
            end
            count     <= count + CNT_W'(1);
            next_addr <= next_addr + NA_W'(1);
            state     <= S_FETCH;
          end else begin
            // Record is beyond the lookahead; leave next_addr pointing at it for a later frame
            state         <= S_IDLE;
            busy_out      <= 1'b0;
            done_out      <= 1'b1;
            hit_ready_out <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered slot outputs; unoccupied slots read as zero
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      block_x_out         <= '0;
      block_y_out         <= '0;
      block_z_out         <= '0;
      block_color_out     <= '0;
      block_direction_out <= '0;
      block_visible_out   <= '0;
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slot_live[i]) begin
          block_x_out[i]         <= slot_x[i];
          block_y_out[i]         <= slot_y[i];
          block_z_out[i]         <= slot_z[i];
          block_color_out[i]     <= slot_color[i];
          block_direction_out[i] <= slot_dir[i];
          block_visible_out[i]   <= !slot_hit[i];
        end else begin
          block_x_out[i]         <= '0;
          block_y_out[i]         <= '0;
          block_z_out[i]         <= '0;
          block_color_out[i]     <= 1'b0;
          block_direction_out[i] <= '0;
          block_visible_out[i]   <= 1'b0;
        end
      end
    end
  end

`ifdef MISS_COUNT_EN
  logic evict_miss;

  // The slot chosen for eviction counts as a miss only if it expired without a hit
  always_comb begin
    evict_miss = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_live[i] && (slot_hit[i] || slot_expired[i]))
        evict_miss = slot_expired[i] && !slot_hit[i];
    end
  end

  // Saturating count of missed blocks
  always_ff @(posedge clk_in) begin
    if (rst_in)
      miss_count_out <= '0;
    else if ((state == S_EVICT) && evict_found && evict_miss && (miss_count_out != 8'hFF))
      miss_count_out <= miss_count_out + 8'd1;
  end
`else
  assign miss_count_out = 8'd0;
`endif

endmodule

// File: tb/tb_block_window_manager.sv
// tb/tb_block_window_manager.sv - randomized self-checking bench for block_window_manager
module tb_block_window_manager;

  localparam int NS = 12;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic               rst_in;
  logic [17:0]        curr_time_in;
  logic               frame_start_in;
  logic               hit_valid_in;
  logic [3:0]         hit_index_in;
  logic               hit_ready_out;
  logic [7:0]         mem_addr_out;
  logic [45:0]        mem_data_in;
  logic [NS-1:0][11:0] block_x_out;
  logic [NS-1:0][11:0] block_y_out;
  logic [NS-1:0][13:0] block_z_out;
  logic [NS-1:0]       block_color_out;
  logic [NS-1:0][2:0]  block_direction_out;
  logic [NS-1:0]       block_visible_out;
  logic               busy_out;
  logic               done_out;
  logic [7:0]         miss_count_out;

  block_window_manager dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .curr_time_in       (curr_time_in),
    .frame_start_in     (frame_start_in),
    .hit_valid_in       (hit_valid_in),
    .hit_index_in       (hit_index_in),
    .hit_ready_out      (hit_ready_out),
    .mem_addr_out       (mem_addr_out),
    .mem_data_in        (mem_data_in),
    .block_x_out        (block_x_out),
    .block_y_out        (block_y_out),
    .block_z_out        (block_z_out),
    .block_color_out    (block_color_out),
    .block_direction_out(block_direction_out),
    .block_visible_out  (block_visible_out),
    .busy_out           (busy_out),
    .done_out           (done_out),
    .miss_count_out     (miss_count_out)
  );

  // Song memory with a single registered read stage
  logic [45:0] mem [256];
  always @(posedge clk_in) mem_data_in <= mem[mem_addr_out];

  typedef struct {
    int t;
    int x;
    int y;
    int c;
    int d;
    bit hit;
  } slot_t;

  slot_t mq[$];
  int m_next, m_frame, m_miss, m_cycles;
  int total, bad;

  logic [NS-1:0][11:0] exp_x, exp_y;
  logic [NS-1:0][13:0] exp_z;
  logic [NS-1:0]       exp_c, exp_v;
  logic [NS-1:0][2:0]  exp_d;

  function automatic int rec_time(int a);
    logic [45:0] w;
    w = mem[a];
    return int'(w[45:28]);
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_next = 0; m_frame = 0; m_miss = 0; m_cycles = 0;
  endfunction

  function automatic void model_hit(int idx);
    if (idx < mq.size()) mq[idx].hit = 1'b1;
  endfunction

  // One vblank update: drop hit/expired blocks, then append in song order while within lookahead
  function automatic void model_frame(int t);
    slot_t keep[$];
    slot_t s;
    logic [45:0] w;
    int ev, loads;
    bit rej, expd;
    ev = 0; loads = 0; rej = 0;
    m_frame = t;
    foreach (mq[i]) begin
      expd = (t > mq[i].t + 512);
      if (mq[i].hit || expd) begin
        ev++;
        if (!mq[i].hit && m_miss < 255) m_miss++;
      end else begin
        keep.push_back(mq[i]);
      end
    end
    mq = keep;
    while (mq.size() < NS && m_next < 256) begin
      if (rec_time(m_next) <= t + 4096) begin
        w = mem[m_next];
        s.t = int'(w[45:28]); s.x = int'(w[27:16]); s.y = int'(w[15:4]);
        s.c = int'(w[3]); s.d = int'(w[2:0]); s.hit = 1'b0;
        mq.push_back(s);
        m_next++;
        loads++;
      end else begin
        rej = 1'b1;
        break;
      end
    end
    m_cycles = ev + 1 + 3 * loads + (rej ? 3 : 1);
  endfunction

  function automatic int clamp_z(int d);
    if (d > 8191) return 8191;
    if (d < -8192) return -8192;
    return d;
  endfunction

  function automatic void build_exp();
    exp_x = '0; exp_y = '0; exp_z = '0; exp_c = '0; exp_v = '0; exp_d = '0;
    foreach (mq[i]) begin
      exp_x[i] = 12'(mq[i].x);
      exp_y[i] = 12'(mq[i].y);
      exp_z[i] = 14'(clamp_z(mq[i].t - m_frame));
      exp_c[i] = mq[i].c[0];
      exp_d[i] = 3'(mq[i].d);
      exp_v[i] = !mq[i].hit;
    end
  endfunction

  function automatic logic [7:0] exp_miss();
`ifdef MISS_COUNT_EN
    return 8'(m_miss);
`else
    return 8'd0;
`endif
  endfunction

  task automatic fill_song();
    int t;
    t = 0;
    for (int i = 0; i < 256; i++) begin
      if (i < 14) t = i * 100;
      else t = t + int'($urandom_range(0, 400));
      mem[i] = {18'(t), 12'($urandom), 12'($urandom), 1'($urandom), 3'($urandom)};
    end
  endtask

  task automatic fill_far();
    for (int i = 0; i < 256; i++)
      mem[i] = {18'(5000 + i * 10), 12'($urandom), 12'($urandom), 1'($urandom), 3'($urandom)};
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
  endtask

  // Pulse frame_start (optionally with a same-cycle hit) and wait for the update to end
  task automatic run_frame(input int t, input bit hv, input int hidx, output int cycles, output bit done_seen);
    @(negedge clk_in);
    curr_time_in   = 18'(t);
    frame_start_in = 1'b1;
    hit_valid_in   = hv;
    hit_index_in   = 4'(hidx);
    if (hv) model_hit(hidx);
    model_frame(t);
    build_exp();
    @(negedge clk_in);
    frame_start_in = 1'b0;
    hit_valid_in   = 1'b0;
    cycles = 0;
    while (busy_out === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk_in);
    end
    done_seen = (done_out === 1'b1);
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    model_reset();
    total++; if (hit_ready_out !== 1'b1) begin bad++; $display("FAIL reset_hit_ready got=%b want=1", hit_ready_out); end
    total++; if ({busy_out, done_out} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b want=00", {busy_out, done_out}); end
    total++; if (mem_addr_out !== 8'd0) begin bad++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr_out); end
    total++; if ({block_x_out, block_y_out, block_z_out} !== '0) begin bad++; $display("FAIL reset_xyz got=nonzero want=0"); end
    total++; if ({block_color_out, block_direction_out, block_visible_out} !== '0) begin bad++; $display("FAIL reset_cdv got=nonzero want=0"); end
    total++; if (miss_count_out !== 8'd0) begin bad++; $display("FAIL reset_miss got=%0d want=0", miss_count_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_first_frame();
    int cyc; bit dn;
    fill_song();
    run_frame(0, 1'b0, 0, cyc, dn);
    total++; if (cyc !== 38) begin bad++; $display("FAIL ff_busy_cycles got=%0d want=38", cyc); end
    total++; if (!dn) begin bad++; $display("FAIL ff_done got=%b want=1", done_out); end
    total++; if (block_visible_out !== 12'hFFF) begin bad++; $display("FAIL ff_visible got=%h want=fff", block_visible_out); end
    total++; if (block_z_out[0] !== 14'd0 || block_z_out[11] !== 14'd1100) begin bad++; $display("FAIL ff_z_ends got=%0d,%0d want=0,1100", block_z_out[0], block_z_out[11]); end
    total++; if (block_x_out !== exp_x || block_y_out !== exp_y) begin bad++; $display("FAIL ff_xy got=%h/%h want=%h/%h", block_x_out, block_y_out, exp_x, exp_y); end
    total++; if (block_color_out !== exp_c || block_direction_out !== exp_d) begin bad++; $display("FAIL ff_cd got=%h/%h want=%h/%h", block_color_out, block_direction_out, exp_c, exp_d); end
    @(negedge clk_in);
    total++; if (done_out !== 1'b0) begin bad++; $display("FAIL ff_done_pulse got=%b want=0", done_out); end
  endtask

  task automatic test_expiry();
    int cyc; bit dn;
    run_frame(700, 1'b0, 0, cyc, dn);
    total++; if (cyc !== m_cycles || cyc !== 10) begin bad++; $display("FAIL exp_cycles got=%0d want=10", cyc); end
    total++; if (int'($signed(block_z_out[0])) != -500) begin bad++; $display("FAIL exp_z0 got=%0d want=-500", $signed(block_z_out[0])); end
    total++; if (block_z_out[10] !== 14'd500 || block_z_out[11] !== 14'd600) begin bad++; $display("FAIL exp_z_new got=%0d,%0d want=500,600", block_z_out[10], block_z_out[11]); end
    total++; if (block_z_out !== exp_z) begin bad++; $display("FAIL exp_z got=%h want=%h", block_z_out, exp_z); end
    total++; if (block_x_out !== exp_x || block_y_out !== exp_y) begin bad++; $display("FAIL exp_xy got=%h/%h want=%h/%h", block_x_out, block_y_out, exp_x, exp_y); end
    total++; if (miss_count_out !== exp_miss()) begin bad++; $display("FAIL exp_miss got=%0d want=%0d", miss_count_out, exp_miss()); end
  endtask

  task automatic test_hit();
    int cyc; bit dn;
    logic [11:0] old4_x;
    old4_x = exp_x[4];
    @(negedge clk_in);
    total++; if (hit_ready_out !== 1'b1) begin bad++; $display("FAIL hit_ready got=%b want=1", hit_ready_out); end
    hit_valid_in = 1'b1; hit_index_in = 4'd3; model_hit(3);
    @(negedge clk_in);
    hit_index_in = 4'd12; model_hit(12);
    @(negedge clk_in);
    hit_valid_in = 1'b0;
    build_exp();
    total++; if (block_visible_out !== exp_v || exp_v !== 12'hFF7) begin bad++; $display("FAIL hit_visible got=%h want=ff7", block_visible_out); end
    run_frame(700, 1'b0, 0, cyc, dn);
    total++; if (cyc !== m_cycles) begin bad++; $display("FAIL hit_cycles got=%0d want=%0d", cyc, m_cycles); end
    total++; if (block_x_out[3] !== old4_x) begin bad++; $display("FAIL hit_shift got=%h want=%h", block_x_out[3], old4_x); end
    total++; if (block_visible_out !== 12'hFFF) begin bad++; $display("FAIL hit_refill got=%h want=fff", block_visible_out); end
    total++; if (block_x_out !== exp_x || block_z_out !== exp_z) begin bad++; $display("FAIL hit_xz got=%h/%h want=%h/%h", block_x_out, block_z_out, exp_x, exp_z); end
    total++; if (miss_count_out !== exp_miss()) begin bad++; $display("FAIL hit_miss got=%0d want=%0d", miss_count_out, exp_miss()); end
  endtask

  task automatic test_ignored_frame();
    int cyc; bit quiet;
    @(negedge clk_in);
    curr_time_in = 18'd800; frame_start_in = 1'b1;
    model_frame(800);
    build_exp();
    @(negedge clk_in);
    frame_start_in = 1'b0;
    cyc = 0;
    while (busy_out === 1'b1 && cyc < 200) begin
      cyc++;
      if (cyc == 2) begin frame_start_in = 1'b1; curr_time_in = 18'd60000; end
      else frame_start_in = 1'b0;
      @(negedge clk_in);
    end
    frame_start_in = 1'b0;
    total++; if (cyc !== m_cycles) begin bad++; $display("FAIL ign_cycles got=%0d want=%0d", cyc, m_cycles); end
    total++; if (block_z_out !== exp_z) begin bad++; $display("FAIL ign_z got=%h want=%h", block_z_out, exp_z); end
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk_in);
      if (busy_out !== 1'b0) quiet = 1'b0;
    end
    total++; if (!quiet) begin bad++; $display("FAIL ign_second_update got=busy want=idle"); end
  endtask

  task automatic test_reset_mid();
    int cyc; bit dn;
    do_reset();
    fill_song();
    run_frame(0, 1'b0, 0, cyc, dn);
    @(negedge clk_in);
    curr_time_in = 18'd700; frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    repeat (4) @(negedge clk_in);
    total++; if (mem_addr_out !== 8'd12 || busy_out !== 1'b1) begin bad++; $display("FAIL mid_in_wait got=addr %0d busy %b want=addr 12 busy 1", mem_addr_out, busy_out); end
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    model_reset();
    total++; if ({busy_out, done_out, hit_ready_out} !== 3'b001) begin bad++; $display("FAIL mid_ctrl got=%b want=001", {busy_out, done_out, hit_ready_out}); end
    total++; if ({block_x_out, block_z_out, block_visible_out, mem_addr_out, miss_count_out} !== '0) begin bad++; $display("FAIL mid_outputs got=nonzero want=0"); end
    run_frame(0, 1'b0, 0, cyc, dn);
    total++; if (block_x_out !== exp_x || cyc !== 38) begin bad++; $display("FAIL mid_reload got=%h/%0d want=%h/38", block_x_out, cyc, exp_x); end
  endtask

  task automatic test_lookahead();
    int cyc; bit dn;
    do_reset();
    fill_far();
    run_frame(0, 1'b0, 0, cyc, dn);
    total++; if (cyc !== 4 || !dn) begin bad++; $display("FAIL la_stop got=%0d cycles done %b want=4 done 1", cyc, dn); end
    total++; if (block_visible_out !== 12'h000) begin bad++; $display("FAIL la_visible got=%h want=000", block_visible_out); end
    run_frame(1000, 1'b0, 0, cyc, dn);
    total++; if (cyc !== m_cycles) begin bad++; $display("FAIL la_cycles got=%0d want=%0d", cyc, m_cycles); end
    total++; if (block_x_out !== exp_x || block_z_out !== exp_z || block_visible_out !== exp_v) begin bad++; $display("FAIL la_reload got=%h/%h want=%h/%h", block_x_out, block_z_out, exp_x, exp_z); end
  endtask

  task automatic test_random();
    int t, cyc, frames, after_end, nh, idx, sidx;
    bit dn, sh;
    do_reset();
    fill_song();
    t = 0; frames = 0; after_end = 0;
    while (after_end < 3 && frames < 200) begin
      nh = $urandom_range(0, 3);
      for (int k = 0; k < nh; k++) begin
        idx = $urandom_range(0, 13);
        @(negedge clk_in);
        total++; if (hit_ready_out !== 1'b1) begin bad++; $display("FAIL rnd_hit_ready got=%b want=1", hit_ready_out); end
        hit_valid_in = 1'b1; hit_index_in = 4'(idx);
        model_hit(idx);
      end
      sh = ($urandom_range(0, 3) == 0);
      sidx = $urandom_range(0, 13);
      t = t + int'($urandom_range(0, 1500));
      if (t > 250000) t = 250000;
      run_frame(t, sh, sidx, cyc, dn);
      total++; if (cyc !== m_cycles || !dn) begin bad++; $display("FAIL rnd_cycles frame=%0d got=%0d done %b want=%0d", frames, cyc, dn, m_cycles); end
      total++; if (block_x_out !== exp_x || block_y_out !== exp_y) begin bad++; $display("FAIL rnd_xy frame=%0d got=%h/%h want=%h/%h", frames, block_x_out, block_y_out, exp_x, exp_y); end
      total++; if (block_z_out !== exp_z) begin bad++; $display("FAIL rnd_z frame=%0d got=%h want=%h", frames, block_z_out, exp_z); end
      total++; if (block_color_out !== exp_c || block_direction_out !== exp_d) begin bad++; $display("FAIL rnd_cd frame=%0d got=%h/%h want=%h/%h", frames, block_color_out, block_direction_out, exp_c, exp_d); end
      total++; if (block_visible_out !== exp_v) begin bad++; $display("FAIL rnd_visible frame=%0d got=%h want=%h", frames, block_visible_out, exp_v); end
      total++; if (miss_count_out !== exp_miss()) begin bad++; $display("FAIL rnd_miss frame=%0d got=%0d want=%0d", frames, miss_count_out, exp_miss()); end
      frames++;
      if (m_next == 256) after_end++;
    end
    total++; if (m_next != 256) begin bad++; $display("FAIL rnd_song_end got=%0d want=256", m_next); end
  endtask

  task automatic test_end_of_song();
    int cyc; bit dn;
    run_frame(262000, 1'b0, 0, cyc, dn);
    total++; if (cyc !== m_cycles || !dn) begin bad++; $display("FAIL eos_cycles got=%0d want=%0d", cyc, m_cycles); end
    total++; if (block_visible_out !== 12'h000 || block_x_out !== '0) begin bad++; $display("FAIL eos_empty got=%h want=000", block_visible_out); end
    total++; if (miss_count_out !== exp_miss()) begin bad++; $display("FAIL eos_miss got=%0d want=%0d", miss_count_out, exp_miss()); end
    run_frame(262000, 1'b0, 0, cyc, dn);
    total++; if (cyc !== 2) begin bad++; $display("FAIL eos_fetch_idle got=%0d want=2", cyc); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_in = 1'b1; frame_start_in = 1'b0; hit_valid_in = 1'b0;
    hit_index_in = 4'd0; curr_time_in = 18'd0;
    fill_song();
    model_reset();
    test_reset();
    test_first_frame();
    test_expiry();
    test_hit();
    test_ignored_frame();
    test_reset_mid();
    test_lookahead();
    test_random();
    test_end_of_song();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
